// File: rtl/ips2l_sync_filter_v1_0.sv
// ips2l_sync_filter_v1_0
// Multi-channel synchroniser for asynchronous status/control flags.
// Each channel has a SYNC_STAGES-deep flop chain, an optional stability
// filter that only adopts a new level after FILTER_CYCLES consecutive
// mismatching samples, rise/fall pulse generation and a sticky glitch flag.
// Channels share only the clock and reset; there is no cross-channel logic.
module ips2l_sync_filter_v1_0 #(
  parameter int unsigned           DATA_WIDTH    = 1,
  parameter int unsigned           SYNC_STAGES   = 2,
  parameter int unsigned           FILTER_CYCLES = 0,
  parameter logic [DATA_WIDTH-1:0] DFT_VALUE     = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sig_async,
  input  logic [DATA_WIDTH-1:0] clr_glitch,
  output logic [DATA_WIDTH-1:0] sig_synced,
  output logic [DATA_WIDTH-1:0] rise_pulse,
  output logic [DATA_WIDTH-1:0] fall_pulse,
  output logic [DATA_WIDTH-1:0] glitch_seen
);

  // Reject illegal configurations at elaboration time.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 8) begin : g_bad_stages
    $error("ips2l_sync_filter_v1_0: SYNC_STAGES must be in 2..8");
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_width
    $error("ips2l_sync_filter_v1_0: DATA_WIDTH must be in 1..32");
  end
  if (FILTER_CYCLES > 65535) begin : g_bad_filter
    $error("ips2l_sync_filter_v1_0: FILTER_CYCLES must be in 0..65535");
  end

  // stage[0] is the only flop allowed to go metastable; only stage[1] reads it.
  logic [DATA_WIDTH-1:0] stage [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] s;          // synchronised, unfiltered sample
  logic [DATA_WIDTH-1:0] level;      // qualified level (filter output)
  logic [DATA_WIDTH-1:0] glitch_set; // a mismatch vanished before qualifying
  logic [DATA_WIDTH-1:0] f_d;        // previous qualified level
  logic [DATA_WIDTH-1:0] glitch_q;

  // Synchroniser chain: shift the raw input through SYNC_STAGES flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= DFT_VALUE;
    end else begin
      stage[0] <= sig_async;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign s = stage[SYNC_STAGES-1];

  if (FILTER_CYCLES == 0) begin : g_bypass
    assign level      = s;
    assign glitch_set = '0;
  end else begin : g_filter
    localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0]      cnt [DATA_WIDTH];
    logic [DATA_WIDTH-1:0] f;

    // Stability filter: count consecutive mismatches, adopt s on the last one.
    // cnt never exceeds CNT_LAST because reaching it always resets it.
    always_ff @(posedge clk) begin
      if (rst) begin
        f <= DFT_VALUE;
        for (int i = 0; i < DATA_WIDTH; i++) cnt[i] <= '0;
      end else begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
          if (s[i] == f[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_LAST) begin
            f[i]   <= s[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end

    // A partially counted mismatch that ends early is a glitch.
    always_comb begin
      glitch_set = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        glitch_set[i] = (s[i] == f[i]) && (cnt[i] != '0);
      end
    end

    assign level = f;
  end

  // Previous-level register for edge detection.
  always_ff @(posedge clk) begin
    if (rst) f_d <= DFT_VALUE;
    else     f_d <= level;
  end

  // Sticky glitch flag; a new event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) glitch_q <= '0;
    else     glitch_q <= (glitch_q & ~clr_glitch) | glitch_set;
  end

  // Pulses are forced low while reset is held so nothing leaks out of reset.
  assign sig_synced  = level;
  assign rise_pulse  = level & ~f_d & {DATA_WIDTH{~rst}};
  assign fall_pulse  = ~level & f_d & {DATA_WIDTH{~rst}};
  assign glitch_seen = glitch_q;

endmodule

// File: tb/tb_ips2l_sync_filter_v1_0.sv
// Bench for ips2l_sync_filter_v1_0.
// dut_a: 4 channels, 2 stages, filter of 4, reset value 1010 (scoreboarded).
// dut_b: 1 channel, 3 stages, filter bypassed, reset value 0.
module tb_ips2l_sync_filter_v1_0;

  localparam int W = 4;
  localparam int S = 2;
  localparam int F = 4;
  localparam logic [W-1:0] DFT = 4'b1010;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] sig_a, clr_a, syn_a, rise_a, fall_a, gl_a;
  logic         sig_b, clr_b, syn_b, rise_b, fall_b, gl_b;

  ips2l_sync_filter_v1_0 #(
    .DATA_WIDTH(W), .SYNC_STAGES(S), .FILTER_CYCLES(F), .DFT_VALUE(DFT)
  ) dut_a (
    .clk(clk), .rst(rst), .sig_async(sig_a), .clr_glitch(clr_a),
    .sig_synced(syn_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
    .glitch_seen(gl_a)
  );

  ips2l_sync_filter_v1_0 #(
    .DATA_WIDTH(1), .SYNC_STAGES(3), .FILTER_CYCLES(0), .DFT_VALUE(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .sig_async(sig_b), .clr_glitch(clr_b),
    .sig_synced(syn_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
    .glitch_seen(gl_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // scoreboard: {synced, rise, fall, glitch} expected after each edge
  logic [4*W-1:0] exp_q[$];

  // reference model state for dut_a
  logic [W-1:0] m_st0, m_st1, m_f, m_gl;
  int           m_run [W];

  // Advance the model by one clock edge and queue the expected outputs.
  function automatic void model_edge(input logic [W-1:0] in,
                                     input logic [W-1:0] clr,
                                     input logic r);
    logic [W-1:0] s, f_old, g, rise, fall;
    g = '0;
    if (r) begin
      m_st0 = DFT; m_st1 = DFT; m_f = DFT; m_gl = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      rise = '0; fall = '0;
    end else begin
      s     = m_st1;
      f_old = m_f;
      for (int i = 0; i < W; i++) begin
        if (s[i] != f_old[i]) begin
          m_run[i]++;
          if (m_run[i] == F) begin
            m_f[i]   = s[i];
            m_run[i] = 0;
          end
        end else begin
          if (m_run[i] > 0) g[i] = 1'b1;
          m_run[i] = 0;
        end
      end
      m_gl  = (m_gl & ~clr) | g;
      m_st1 = m_st0;
      m_st0 = in;
      rise  = m_f & ~f_old;
      fall  = ~m_f & f_old;
    end
    exp_q.push_back({m_f, rise, fall, m_gl});
  endfunction

  // driver: apply inputs at the falling edge, check after the next rising edge
  task automatic tick(input logic [W-1:0] a, input logic [W-1:0] c,
                      input logic r, input logic b);
    logic [4*W-1:0] exp_v, act_v;
    sig_a = a; clr_a = c; rst = r; sig_b = b; clr_b = 1'b0;
    model_edge(a, c, r);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    exp_v = exp_q.pop_front();
    act_v = {syn_a, rise_a, fall_a, gl_a};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL scoreboard cyc=%0d syn/rise/fall/gl got=%h_%h_%h_%h want=%h_%h_%h_%h",
               cyc, syn_a, rise_a, fall_a, gl_a,
               exp_v[4*W-1 -: W], exp_v[3*W-1 -: W], exp_v[2*W-1 -: W], exp_v[W-1:0]);
    end
  endtask

  task automatic test_reset();
    tick(DFT, '0, 1'b1, 1'b0);
    tick(DFT, '0, 1'b1, 1'b0);
    checks++;
    if ({syn_a, rise_a, fall_a, gl_a} !== {DFT, 12'h000}) begin
      errors++;
      $display("FAIL reset_a got=%h_%h_%h_%h want=%h_0_0_0", syn_a, rise_a, fall_a, gl_a, DFT);
    end
    checks++;
    if ({syn_b, rise_b, fall_b, gl_b} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_b got=%b%b%b%b want=0000", syn_b, rise_b, fall_b, gl_b);
    end
    // first cycle after release: no pulses
    tick(DFT, '0, 1'b0, 1'b0);
    checks++;
    if ((rise_a | fall_a) !== '0 || syn_a !== DFT) begin
      errors++;
      $display("FAIL release got syn=%h rise=%h fall=%h want syn=%h no pulses", syn_a, rise_a, fall_a, DFT);
    end
  endtask

  task automatic test_bypass();
    logic [3:0] got_syn, got_rise;
    got_syn = '0; got_rise = '0;
    for (int k = 0; k < 4; k++) begin
      tick(DFT, '0, 1'b0, 1'b1);
      got_syn[k]  = syn_b;
      got_rise[k] = rise_b;
    end
    checks++;
    if (got_syn !== 4'b1100 || got_rise !== 4'b0100) begin
      errors++;
      $display("FAIL bypass_rise got syn=%b rise=%b want syn=1100 rise=0100", got_syn, got_rise);
    end
    got_syn = '0;
    for (int k = 0; k < 4; k++) begin
      tick(DFT, '0, 1'b0, 1'b0);
      got_syn[k] = fall_b;
    end
    checks++;
    if (got_syn !== 4'b0100 || syn_b !== 1'b0 || gl_b !== 1'b0) begin
      errors++;
      $display("FAIL bypass_fall got fall=%b syn=%b gl=%b want fall=0100 syn=0 gl=0", got_syn, syn_b, gl_b);
    end
  endtask

  task automatic test_glitch();
    logic saw_high;
    logic [W-1:0] pulses;
    saw_high = 1'b0; pulses = '0;
    for (int k = 0; k < 3; k++) begin
      tick(DFT | 4'b0001, '0, 1'b0, 1'b0);
      saw_high |= syn_a[0]; pulses |= rise_a | fall_a;
    end
    for (int k = 0; k < 5; k++) begin
      tick(DFT, '0, 1'b0, 1'b0);
      saw_high |= syn_a[0]; pulses |= rise_a | fall_a;
    end
    checks++;
    if (saw_high !== 1'b0 || pulses !== '0 || gl_a !== 4'b0001) begin
      errors++;
      $display("FAIL glitch_short got high=%b pulses=%h gl=%h want 0 0 1", saw_high, pulses, gl_a);
    end
    tick(DFT, 4'b0001, 1'b0, 1'b0);
    checks++;
    if (gl_a !== 4'b0000) begin
      errors++;
      $display("FAIL glitch_clear got gl=%h want 0", gl_a);
    end
  endtask

  task automatic test_qualify();
    int first_rise, n_rise, first_fall, n_fall;
    logic [W-1:0] other;
    first_rise = 0; n_rise = 0; first_fall = 0; n_fall = 0; other = '0;
    for (int k = 1; k <= 10; k++) begin
      tick(DFT | 4'b0001, '0, 1'b0, 1'b0);
      if (syn_a[0] && first_rise == 0) first_rise = k;
      if (rise_a[0]) n_rise++;
      other |= (rise_a | fall_a) & 4'b1110;
    end
    checks++;
    if (first_rise != S + F || n_rise != 1) begin
      errors++;
      $display("FAIL qualify_rise got edge=%0d pulses=%0d want edge=%0d pulses=1", first_rise, n_rise, S + F);
    end
    for (int k = 1; k <= 10; k++) begin
      tick(DFT, '0, 1'b0, 1'b0);
      if (!syn_a[0] && first_fall == 0) first_fall = k;
      if (fall_a[0]) n_fall++;
      other |= (rise_a | fall_a) & 4'b1110;
    end
    checks++;
    if (first_fall != S + F || n_fall != 1) begin
      errors++;
      $display("FAIL qualify_fall got edge=%0d pulses=%0d want edge=%0d pulses=1", first_fall, n_fall, S + F);
    end
    checks++;
    if (other !== '0 || gl_a !== '0) begin
      errors++;
      $display("FAIL independence got other_pulses=%h gl=%h want 0 0", other, gl_a);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] pulses;
    pulses = '0;
    for (int k = 0; k < 5; k++) tick(DFT | 4'b0001, '0, 1'b0, 1'b0);
    tick(DFT, '0, 1'b1, 1'b0);
    checks++;
    if (syn_a !== DFT || gl_a !== '0 || (rise_a | fall_a) !== '0) begin
      errors++;
      $display("FAIL reset_mid got syn=%h gl=%h pulses=%h want %h 0 0", syn_a, gl_a, rise_a | fall_a, DFT);
    end
    for (int k = 0; k < 6; k++) begin
      tick(DFT, '0, 1'b0, 1'b0);
      pulses |= rise_a | fall_a;
    end
    checks++;
    if (gl_a !== '0 || pulses !== '0 || syn_a !== DFT) begin
      errors++;
      $display("FAIL reset_discard got gl=%h pulses=%h syn=%h want 0 0 %h", gl_a, pulses, syn_a, DFT);
    end
  endtask

  task automatic test_set_clear();
    tick(DFT | 4'b0001, '0, 1'b0, 1'b0);
    tick(DFT | 4'b0001, '0, 1'b0, 1'b0);
    tick(DFT, '0, 1'b0, 1'b0);
    tick(DFT, '0, 1'b0, 1'b0);
    checks++;
    if (gl_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL set_clear_pre got gl0=%b want 0", gl_a[0]);
    end
    // glitch is recognised on this edge, clear asserted on the same edge
    tick(DFT, 4'b0001, 1'b0, 1'b0);
    checks++;
    if (gl_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL set_wins got gl0=%b want 1", gl_a[0]);
    end
    tick(DFT, 4'b1111, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] cur, clr;
    logic r;
    cur = DFT;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 5) == 0) cur[i] = ~cur[i];
      clr = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 15)) : '0;
      r   = ($urandom_range(0, 99) == 0);
      tick(cur, clr, r, 1'b0);
    end
  endtask

  initial begin
    sig_a = DFT; clr_a = '0; rst = 1'b1; sig_b = 1'b0; clr_b = 1'b0;
    test_reset();
    test_bypass();
    test_glitch();
    test_qualify();
    test_reset_mid();
    test_set_clear();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ips2l_sync_filter_v1_0.md
Name: ips2l_sync_filter_v1_0

Overview:
Parametrised multi-channel synchroniser for asynchronous control and status inputs entering a single clock domain, e.g. DDR PHY lock, calibration done and PLL status flags. Each channel has a configurable-depth flop chain and an optional stability (deglitch) filter. It produces a qualified level, one-cycle rise/fall pulses and a sticky glitch flag. It replaces the fixed 2-flop synchroniser wherever filtering or edge detection is needed.

Parameters:
DATA_WIDTH, 1, number of independent channels (1..32)
SYNC_STAGES, 2, flops in the synchroniser chain per channel (legal 2..8; elaboration error otherwise)
FILTER_CYCLES, 0, consecutive cycles the synchronised value must differ from the output before the output adopts it; 0 = filter bypassed (legal 0..65535)
DFT_VALUE, {DATA_WIDTH{1'b0}}, per-channel reset value of all chain flops and outputs

Ports:
clk  input  1  sampling clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
sig_async  input  DATA_WIDTH  asynchronous inputs, one bit per channel
clr_glitch  input  DATA_WIDTH  per-channel clear for glitch_seen
sig_synced  output  DATA_WIDTH  qualified, synchronised level
rise_pulse  output  DATA_WIDTH  1-cycle pulse when sig_synced goes 0->1
fall_pulse  output  DATA_WIDTH  1-cycle pulse when sig_synced goes 1->0
glitch_seen  output  DATA_WIDTH  sticky: a mismatch disappeared before qualifying

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on port rst. All registers update only on the clk rising edge, with rst sampled there.
- Reset values:
  - Chain flops, filtered level and previous-level register = DFT_VALUE.
  - Filter counters = 0; glitch_seen = 0.
  - rise_pulse and fall_pulse = 0 during reset and in the first cycle after release. No spurious edge may appear out of reset.
- Synchroniser:
  - Per channel, stage[0] <= sig_async; stage[i] <= stage[i-1].
  - s = stage[SYNC_STAGES-1].
  - A level held stable before edge 1 is visible on s after SYNC_STAGES edges.
- Filter, FILTER_CYCLES = 0:
  - sig_synced = s directly; no counter is instantiated.
  - Latency is SYNC_STAGES cycles.
- Filter, FILTER_CYCLES >= 1: per channel, counter cnt has width clog2(FILTER_CYCLES+1), and f is the output register. Each edge:
  - s == f: cnt <= 0. If cnt != 0 before this edge, glitch_seen <= 1.
  - s != f and cnt == FILTER_CYCLES-1: f <= s, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Resulting latency is SYNC_STAGES + FILTER_CYCLES edges.
  - A mismatch lasting fewer than FILTER_CYCLES cycles never reaches sig_synced and sets glitch_seen.
  - The counter never wraps; it saturates by construction at FILTER_CYCLES-1.
- Edge detect:
  - f_d <= sig_synced each edge.
  - rise_pulse = sig_synced & ~f_d; fall_pulse = ~sig_synced & f_d.
  - Each pulse is exactly 1 cycle, coincident with the first cycle of the new level.
- glitch_seen:
  - Set as above.
  - Cleared by clr_glitch[i]=1 at an edge.
  - Simultaneous set and clear: set wins, so the event is not lost.
- Channels are fully independent; activity on one never affects another.
- Reset mid-operation: asserting rst for one edge returns all state to reset values. Any partially counted mismatch is discarded, with no pulse and no glitch flag.
- Inputs are assumed metastable only at stage[0]. No logic other than stage[1] may read stage[0].

Test Plan:
1. SYNC_STAGES=3, FILTER_CYCLES=0, DFT=0: sig_async 0->1 before edge 1 -> sig_synced=1 after edge 3; rise_pulse high for exactly that one cycle.
2. SYNC_STAGES=2, FILTER_CYCLES=4: input high for 3 cycles, then low -> sig_synced stays 0, no pulses, glitch_seen=1. Then clr_glitch pulse -> glitch_seen=0 next cycle.
3. Same config, input high for 10 cycles -> sig_synced rises after edge 6 (2+4); rise_pulse 1 cycle. Input low -> fall_pulse 6 cycles after the falling input.
4. DATA_WIDTH=4, DFT_VALUE=4'b1010: reset then release with inputs equal to 1010 -> outputs 1010, zero pulses in every cycle. Toggle only bit 0 -> only rise_pulse[0] asserts.
5. FILTER_CYCLES=4, mismatch counted to 3, then rst for 1 cycle -> cnt=0, sig_synced=DFT, no pulse, glitch_seen=0.
6. glitch set and clr_glitch asserted on the same edge -> glitch_seen=1 afterwards.
